// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - opcodes, response codes and state encoding for the UART bus bridge
package uart_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_DATA      = 3'd2,
        S_BUS_WR    = 3'd3,
        S_BUS_RD    = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_RESP      = 3'd6,
        S_RESP_WAIT = 3'd7
    } state_t;

endpackage

// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - byte-stream command parser acting as 32-bit bus initiator
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rx_data_8b_i/rx_valid_i received byte and its one-cycle strobe
//   tx_data_8b_o/tx_valid_o response byte and one-cycle write strobe to transmitter
//   tx_busy_i               transmitter busy
//   addr_32b_o, wdata_32b_o bus address / write data (hold until next frame)
//   wren_o, rden_o          one-cycle bus write / read strobes
//   rdata_32b_i/rdata_valid_i bus read data and qualifier
//   busy_o                  high whenever the parser is not idle
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int FRAME_TO = 100000,
    parameter int RD_TO    = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_8b_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_8b_o,
    output logic        tx_valid_o,
    input  logic        tx_busy_i,
    output logic [31:0] addr_32b_o,
    output logic        wren_o,
    output logic        rden_o,
    output logic [31:0] wdata_32b_o,
    input  logic [31:0] rdata_32b_i,
    input  logic        rdata_valid_i,
    output logic        busy_o
);

    localparam logic [16:0] FRAME_LIM = 17'(FRAME_TO - 1);
    localparam logic [16:0] RD_LIM    = 17'(RD_TO - 1);

    state_t      state;
    state_t      state_nxt;
    logic [16:0] cnt;
    logic [1:0]  byte_cnt;
    logic        is_wr;
    logic [31:0] resp_sr;
    logic [2:0]  resp_cnt;
    logic        byte_acc;
    logic        guard_done;

    assign busy_o       = (state != S_IDLE);
    assign wren_o       = (state == S_BUS_WR);
    assign rden_o       = (state == S_BUS_RD);
    assign tx_valid_o   = (state == S_RESP) && !tx_busy_i;
    assign tx_data_8b_o = resp_sr[31:24];

    // The shared counter is cleared on RESP_WAIT entry, so a nonzero value
    // means the one-cycle guard after a tx strobe has elapsed.
    assign guard_done = (cnt != 17'd0);

    always_comb begin
        state_nxt = state;
        byte_acc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid_i) begin
                    byte_acc  = 1'b1;
                    state_nxt = (rx_data_8b_i == OP_WR || rx_data_8b_i == OP_RD) ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                // An arriving byte takes precedence over an expiring frame timer.
                if (rx_valid_i) begin
                    byte_acc = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = is_wr ? S_DATA : S_BUS_RD;
                    end
                end else if (cnt == FRAME_LIM) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    byte_acc = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = S_BUS_WR;
                    end
                end else if (cnt == FRAME_LIM) begin
                    state_nxt = S_IDLE;
                end
            end
            S_BUS_WR:  state_nxt = S_RESP;
            S_BUS_RD:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rdata_valid_i || cnt == RD_LIM) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (!tx_busy_i) begin
                    state_nxt = S_RESP_WAIT;
                end
            end
            S_RESP_WAIT: begin
                if (guard_done && !tx_busy_i) begin
                    state_nxt = (resp_cnt == 3'd1) ? S_IDLE : S_RESP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= 17'd0;
            byte_cnt    <= 2'd0;
            is_wr       <= 1'b0;
            resp_sr     <= 32'd0;
            resp_cnt    <= 3'd0;
            addr_32b_o  <= 32'd0;
            wdata_32b_o <= 32'd0;
        end else begin
            state <= state_nxt;

            if (byte_acc || state_nxt != state) begin
                cnt <= 17'd0;
            end else if (cnt != '1) begin
                cnt <= cnt + 17'd1;
            end

            case (state)
                S_IDLE: begin
                    // Preload the error response; a valid opcode overwrites it later.
                    if (rx_valid_i) begin
                        is_wr    <= (rx_data_8b_i == OP_WR);
                        byte_cnt <= 2'd0;
                        resp_sr  <= {RSP_ERR, 24'd0};
                        resp_cnt <= 3'd1;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        addr_32b_o <= {addr_32b_o[23:0], rx_data_8b_i};
                        byte_cnt   <= byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        wdata_32b_o <= {wdata_32b_o[23:0], rx_data_8b_i};
                        byte_cnt    <= byte_cnt + 2'd1;
                    end
                end
                S_BUS_WR: begin
                    resp_sr  <= {RSP_OK, 24'd0};
                    resp_cnt <= 3'd1;
                end
                S_RD_WAIT: begin
                    if (rdata_valid_i) begin
                        resp_sr  <= rdata_32b_i;
                        resp_cnt <= 3'd4;
                    end else if (cnt == RD_LIM) begin
                        resp_sr  <= {RSP_ERR, 24'd0};
                        resp_cnt <= 3'd1;
                    end
                end
                S_RESP_WAIT: begin
                    if (guard_done && !tx_busy_i) begin
                        resp_sr  <= {resp_sr[23:0], 8'd0};
                        resp_cnt <= resp_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - scoreboard bench for uart_bus_bridge
module tb_uart_bus_bridge;

    localparam int FRAME_TO = 40;
    localparam int RD_TO    = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic [31:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;
    logic        rdata_valid = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tx = -100;
    int busy_left = 0;
    logic seen_tx = 1'b0;

    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];

    uart_bus_bridge #(.FRAME_TO(FRAME_TO), .RD_TO(RD_TO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_data_8b_i(rx_data),
        .rx_valid_i(rx_valid),
        .tx_data_8b_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_busy_i(tx_busy),
        .addr_32b_o(addr),
        .wren_o(wren),
        .rden_o(rden),
        .wdata_32b_o(wdata),
        .rdata_32b_i(rdata),
        .rdata_valid_i(rdata_valid),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard whenever the DUT emits a strobe.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (wren && rden) begin
                checks++; errors++;
                $display("FAIL strobe_overlap: wren and rden both high at cycle %0d", cyc);
            end
            if (tx_valid) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %02h, expected none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e);
                    end
                end
                checks++;
                if (tx_busy !== 1'b0 || cyc - last_tx < 2) begin
                    errors++;
                    $display("FAIL tx_spacing: busy %0b gap %0d, expected busy 0 gap>=2", tx_busy, cyc - last_tx);
                end
                last_tx = cyc;
                seen_tx = 1'b1;
            end
            if (wren) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr %08h data %08h, expected none", addr, wdata);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    if ({addr, wdata} !== e) begin
                        errors++;
                        $display("FAIL wr_txn: got %08h/%08h, expected %08h/%08h", addr, wdata, e[63:32], e[31:0]);
                    end
                end
            end
            if (rden) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: addr %08h, expected none", addr);
                end else begin
                    logic [31:0] e;
                    e = exp_rd.pop_front();
                    if (addr !== e) begin
                        errors++;
                        $display("FAIL rd_addr: got %08h, expected %08h", addr, e);
                    end
                end
            end
        end
    end

    // Transmitter model: busy for several cycles after each accepted byte.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            tx_busy = 1'b0; busy_left = 0; seen_tx = 1'b0;
        end else if (seen_tx) begin
            seen_tx = 1'b0; tx_busy = 1'b1; busy_left = 4;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < budget) begin
            tick(); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: busy %0b pending tx %0d wr %0d rd %0d, expected all 0",
                     name, busy, exp_tx.size(), exp_wr.size(), exp_rd.size());
            exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        end
    endtask

    task automatic respond_read(input logic [31:0] d, input logic spurious);
        // Called right after the last address byte: rden is high now.
        checks++;
        if (rden !== 1'b1) begin
            errors++;
            $display("FAIL rd_latency: rden %0b, expected 1", rden);
        end
        if (spurious) begin
            rdata = 32'hBAD0BAD0; rdata_valid = 1'b1;
        end
        tick();
        rdata_valid = 1'b0;
        tick(); tick();
        rdata = d; rdata_valid = 1'b1;
        tick();
        rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_valid, wren, rden, busy} !== 4'b0 || tx_data !== 8'd0 || addr !== 32'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: tv %0b wr %0b rd %0b busy %0b txd %02h addr %08h wd %08h, expected all 0",
                     tx_valid, wren, rden, busy, tx_data, addr, wdata);
        end
    endtask

    task automatic test_write(input logic [31:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_word(a); send_word(d);
        checks++;
        if (wren !== 1'b1) begin
            errors++;
            $display("FAIL wr_latency: wren %0b, expected 1", wren);
        end
        wait_idle("write", 100);
        checks++;
        if (addr !== a || wdata !== d) begin
            errors++;
            $display("FAIL wr_hold: %08h/%08h, expected %08h/%08h", addr, wdata, a, d);
        end
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] d);
        exp_rd.push_back(a);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
        send_byte(8'h52); send_word(a);
        respond_read(d, 1'b1);
        wait_idle("read", 200);
    endtask

    task automatic test_rd_timeout();
        exp_rd.push_back(32'h0000_2000);
        exp_tx.push_back(8'h45);
        send_byte(8'h52); send_word(32'h0000_2000);
        wait_idle("rd_timeout", RD_TO + 60);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_timeout_idle: busy %0b, expected 0", busy);
        end
    endtask

    task automatic test_bad_opcode();
        exp_tx.push_back(8'h45);
        send_byte(8'hAA);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
            errors++;
            $display("FAIL bad_op_latency: tv %0b data %02h, expected 1/45", tx_valid, tx_data);
        end
        wait_idle("bad_op", 50);
        test_write(32'h0000_0004, 32'h0102_0304);
    endtask

    task automatic test_frame_timeout();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy: busy %0b, expected 1", busy);
        end
        repeat (FRAME_TO + 5) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_abort: busy %0b, expected 0", busy);
        end
        test_read(32'h0000_0008, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        rst = 1'b1;
        tick();
        checks++;
        if ({tx_valid, wren, rden, busy} !== 4'b0 || tx_data !== 8'd0 || addr !== 32'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL midframe_reset: tv %0b wr %0b rd %0b busy %0b addr %08h wd %08h, expected all 0",
                     tx_valid, wren, rden, busy, addr, wdata);
        end
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_idle: busy %0b, expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        test_write(32'h0000_0040, 32'h0BAD_CAFE);
        test_read(32'h0000_0040, 32'h0BAD_CAFE);
        test_write(32'hFFFF_FFFC, 32'h0000_0000);
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_write(32'h0000_1000, 32'hDEAD_BEEF);
        test_read(32'h0000_1000, 32'h1234_5678);
        test_rd_timeout();
        test_bad_opcode();
        test_frame_timeout();
        test_reset_midframe();
        test_back_to_back();
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
